// File: rtl/capture_supervisor.sv
// capture_supervisor
// Brings an array of signal_capture channels out of reset, waits for every
// supervised channel to lock (retrying on timeout), then watches for lock
// loss and acknowledges/counts invalid events while running.
module capture_supervisor #(
   parameter int AXNUM   = 24,
   parameter int RCYC    = 4,
   parameter int TBITS   = 16,
   parameter int TIMEOUT = 50000,
   parameter int RETRY   = 3,
   parameter int EBITS   = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [AXNUM-1:0] mask_i,
   input  logic             clr_i,
   input  logic [AXNUM-1:0] locked_i,
   input  logic [AXNUM-1:0] invalid_i,
   output logic [AXNUM-1:0] ack_o,
   output logic             cap_rst_o,
   output logic             cap_ce_o,
   output logic             run_o,
   output logic             fail_o,
   output logic [2:0]       state_o,
   output logic [EBITS-1:0] errs_o,
   output logic [AXNUM-1:0] lost_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RESET   = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_RUN     = 3'd3,
      ST_FAULT   = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   // RESET down-counter is loaded with RCYC-1 so the state lasts RCYC cycles.
   localparam logic [3:0]       RCNT_LOAD   = 4'(RCYC - 1);
   localparam logic [3:0]       RCNT_ONE    = 4'd1;
   localparam logic [TBITS-1:0] TIMER_LAST  = TBITS'(TIMEOUT - 1);
   localparam logic [TBITS-1:0] TIMER_ONE   = TBITS'(1);
   localparam logic [2:0]       RETRY_MAX   = 3'(RETRY);
   localparam logic [2:0]       RETRY_ONE   = 3'd1;
   localparam logic [EBITS-1:0] ERR_MAX     = {EBITS{1'b1}};
   localparam logic [EBITS-1:0] ERR_ONE     = EBITS'(1);

   state_t             state_r;
   state_t             state_next_s;
   state_t             fsm_next_s;
   logic [3:0]         rcnt_r;
   logic [3:0]         rcnt_next_s;
   logic [TBITS-1:0]   timer_r;
   logic [TBITS-1:0]   timer_next_s;
   logic [2:0]         retry_r;
   logic [2:0]         retry_next_s;
   logic               all_locked_s;
   logic [AXNUM-1:0]   lost_bits_s;
   logic [AXNUM-1:0]   new_inv_s;
   logic [AXNUM-1:0]   ack_r;
   logic [EBITS-1:0]   errs_r;
   logic [AXNUM-1:0]   lost_r;
   logic               cap_rst_r;
   logic               cap_ce_r;
   logic               run_r;
   logic               fail_r;

   // Unsupervised channels count as locked; ack_r masks the second cycle of a
   // held invalid so each event is seen once.
   assign all_locked_s = &(locked_i | ~mask_i);
   assign lost_bits_s  = mask_i & ~locked_i;
   assign new_inv_s    = invalid_i & mask_i & ~ack_r;

   // Next-state and counter update; en_i low overrides every transition.
   always_comb begin
      fsm_next_s   = state_r;
      rcnt_next_s  = rcnt_r;
      timer_next_s = timer_r;
      retry_next_s = retry_r;
      case (state_r)
         ST_IDLE: begin
            retry_next_s = 3'd0;
            rcnt_next_s  = RCNT_LOAD;
            timer_next_s = '0;
            if (en_i && (|mask_i)) begin
               fsm_next_s = ST_RESET;
            end else begin
               fsm_next_s = ST_IDLE;
            end
         end
         ST_RESET: begin
            timer_next_s = '0;
            if (rcnt_r == 4'd0) begin
               fsm_next_s = ST_ACQUIRE;
            end else begin
               rcnt_next_s = rcnt_r - RCNT_ONE;
            end
         end
         ST_ACQUIRE: begin
            if (all_locked_s) begin
               fsm_next_s   = ST_RUN;
               retry_next_s = 3'd0;
            end else if (timer_r == TIMER_LAST) begin
               fsm_next_s = ST_FAULT;
            end else begin
               timer_next_s = timer_r + TIMER_ONE;
            end
         end
         ST_RUN: begin
            if (|lost_bits_s) begin
               fsm_next_s = ST_FAULT;
            end else begin
               fsm_next_s = ST_RUN;
            end
         end
         ST_FAULT: begin
            if (retry_r < RETRY_MAX) begin
               retry_next_s = retry_r + RETRY_ONE;
               rcnt_next_s  = RCNT_LOAD;
               fsm_next_s   = ST_RESET;
            end else begin
               fsm_next_s = ST_HALT;
            end
         end
         ST_HALT: begin
            fsm_next_s = ST_HALT;
         end
         default: begin
            fsm_next_s = ST_IDLE;
         end
      endcase
      if (en_i) begin
         state_next_s = fsm_next_s;
      end else begin
         state_next_s = ST_IDLE;
      end
   end

   // State, counters and Moore outputs (decoded from the next state so the
   // registered outputs always match state_r).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= ST_IDLE;
         rcnt_r    <= 4'd0;
         timer_r   <= '0;
         retry_r   <= 3'd0;
         cap_rst_r <= 1'b1;
         cap_ce_r  <= 1'b0;
         run_r     <= 1'b0;
         fail_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         rcnt_r    <= rcnt_next_s;
         timer_r   <= timer_next_s;
         retry_r   <= retry_next_s;
         cap_rst_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_RESET) ||
                      (state_next_s == ST_HALT);
         cap_ce_r  <= (state_next_s == ST_ACQUIRE) || (state_next_s == ST_RUN) ||
                      (state_next_s == ST_FAULT);
         run_r     <= (state_next_s == ST_RUN);
         fail_r    <= (state_next_s == ST_HALT);
      end
   end

   // Invalid acknowledge: one-cycle pulse per new event while captures are live.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_r <= '0;
      end else if ((state_r == ST_ACQUIRE) || (state_r == ST_RUN)) begin
         ack_r <= new_inv_s;
      end else begin
         ack_r <= '0;
      end
   end

   // Saturating error counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         errs_r <= '0;
      end else if (clr_i) begin
         errs_r <= '0;
      end else if ((state_r == ST_RUN) && (|new_inv_s) && (errs_r != ERR_MAX)) begin
         errs_r <= errs_r + ERR_ONE;
      end else begin
         errs_r <= errs_r;
      end
   end

   // Sticky record of supervised channels that dropped lock while running.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lost_r <= '0;
      end else if (clr_i) begin
         lost_r <= '0;
      end else if (state_r == ST_RUN) begin
         lost_r <= lost_r | lost_bits_s;
      end else begin
         lost_r <= lost_r;
      end
   end

   assign ack_o     = ack_r;
   assign cap_rst_o = cap_rst_r;
   assign cap_ce_o  = cap_ce_r;
   assign run_o     = run_r;
   assign fail_o    = fail_r;
   assign state_o   = state_r;
   assign errs_o    = errs_r;
   assign lost_o    = lost_r;

endmodule

// File: tb/tb_capture_supervisor.sv
// Directed bench for capture_supervisor (AXNUM=4, RCYC=4, TIMEOUT=16, RETRY=2).
module tb_capture_supervisor;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       en_i = 1'b0;
   logic [3:0] mask_i = 4'h0;
   logic       clr_i = 1'b0;
   logic [3:0] locked_i = 4'h0;
   logic [3:0] invalid_i = 4'h0;
   logic [3:0] ack_o;
   logic       cap_rst_o;
   logic       cap_ce_o;
   logic       run_o;
   logic       fail_o;
   logic [2:0] state_o;
   logic [7:0] errs_o;
   logic [3:0] lost_o;

   int nvec = 0;
   int nerr = 0;

   capture_supervisor #(
      .AXNUM(4), .RCYC(4), .TBITS(16), .TIMEOUT(16), .RETRY(2), .EBITS(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .mask_i(mask_i),
      .clr_i(clr_i), .locked_i(locked_i), .invalid_i(invalid_i),
      .ack_o(ack_o), .cap_rst_o(cap_rst_o), .cap_ce_o(cap_ce_o),
      .run_o(run_o), .fail_o(fail_o), .state_o(state_o),
      .errs_o(errs_o), .lost_o(lost_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec = nvec + 1;
      assert (obs === exp) else begin
         nerr = nerr + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected state in the never-locked retry run, cycle c after en_i sampled.
   function automatic logic [31:0] retry_state(input int c);
      int p;
      if (c >= 64) return 32'd5;
      p = (c - 1) % 21;
      if (p < 4) return 32'd1;
      if (p < 20) return 32'd2;
      return 32'd4;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      tick();
      tick();
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_cap_rst", 32'(cap_rst_o), 32'd1);
      chk("rst_cap_ce", 32'(cap_ce_o), 32'd0);
      chk("rst_run", 32'(run_o), 32'd0);
      chk("rst_fail", 32'(fail_o), 32'd0);
      chk("rst_ack", 32'(ack_o), 32'd0);
      chk("rst_errs", 32'(errs_o), 32'd0);
      chk("rst_lost", 32'(lost_o), 32'd0);
      rst_ni = 1'b1;
      tick();
      tick();
      chk("idle_en0", 32'(state_o), 32'd0);

      // Bring-up: en_i sampled in cycle 0, lock in cycle 10
      en_i = 1'b1;
      mask_i = 4'hF;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk("bu_cap_rst", 32'(cap_rst_o), (c <= 4) ? 32'd1 : 32'd0);
         chk("bu_cap_ce", 32'(cap_ce_o), (c >= 5) ? 32'd1 : 32'd0);
         chk("bu_run", 32'(run_o), (c >= 11) ? 32'd1 : 32'd0);
         chk("bu_state", 32'(state_o), (c <= 4) ? 32'd1 : ((c <= 10) ? 32'd2 : 32'd3));
         if (c == 10) locked_i = 4'hF;
      end

      // Single invalid event, held for two cycles as the capture does
      invalid_i = 4'b0100;
      tick();
      chk("inv_ack", 32'(ack_o), 32'h4);
      chk("inv_errs", 32'(errs_o), 32'd1);
      tick();
      invalid_i = 4'b0000;
      chk("inv_ack_drop", 32'(ack_o), 32'h0);
      chk("inv_no_double", 32'(errs_o), 32'd1);
      for (int i = 0; i < 300; i++) begin
         invalid_i = 4'b0100;
         tick();
         invalid_i = 4'b0000;
         tick();
         if (i == 198) chk("errs_200", 32'(errs_o), 32'd200);
      end
      chk("errs_sat", 32'(errs_o), 32'd255);
      chk("errs_state_run", 32'(state_o), 32'd3);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("errs_clr", 32'(errs_o), 32'd0);

      // Lock loss on channel 1 and recovery
      locked_i = 4'b1101;
      tick();
      chk("ll_lost", 32'(lost_o), 32'h2);
      chk("ll_fault", 32'(state_o), 32'd4);
      chk("ll_run_low", 32'(run_o), 32'd0);
      tick();
      chk("ll_reset", 32'(state_o), 32'd1);
      locked_i = 4'hF;
      repeat (5) tick();
      chk("ll_relock_run", 32'(run_o), 32'd1);
      chk("ll_sticky", 32'(lost_o), 32'h2);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("ll_clr", 32'(lost_o), 32'h0);

      // Retry exhaustion, never locked
      en_i = 1'b0;
      tick();
      chk("rx_idle", 32'(state_o), 32'd0);
      locked_i = 4'h0;
      en_i = 1'b1;
      for (int c = 1; c <= 66; c++) begin
         tick();
         chk("rx_state", 32'(state_o), retry_state(c));
         chk("rx_fail", 32'(fail_o), (c >= 64) ? 32'd1 : 32'd0);
      end
      en_i = 1'b0;
      tick();
      chk("rx_exit_state", 32'(state_o), 32'd0);
      chk("rx_exit_fail", 32'(fail_o), 32'd0);
      chk("rx_exit_cap_rst", 32'(cap_rst_o), 32'd1);

      // Masking: channel 3 unsupervised and unlocked
      mask_i = 4'h7;
      locked_i = 4'b0111;
      en_i = 1'b1;
      repeat (6) tick();
      chk("mk_run", 32'(run_o), 32'd1);
      chk("mk_state", 32'(state_o), 32'd3);
      invalid_i = 4'b1000;
      tick();
      invalid_i = 4'b0000;
      chk("mk_no_ack", 32'(ack_o), 32'h0);
      tick();
      chk("mk_errs", 32'(errs_o), 32'd0);
      // Widening the mask in RUN exposes the unlocked channel at once
      mask_i = 4'hF;
      tick();
      chk("mk_widen_fault", 32'(state_o), 32'd4);
      chk("mk_widen_lost", 32'(lost_o), 32'h8);
      en_i = 1'b0;
      tick();
      mask_i = 4'h0;
      en_i = 1'b1;
      repeat (3) tick();
      chk("mk_zero_idle", 32'(state_o), 32'd0);

      // Asynchronous reset in the middle of RUN
      mask_i = 4'h7;
      repeat (6) tick();
      chk("ar_pre_run", 32'(state_o), 32'd3);
      invalid_i = 4'b0001;
      tick();
      invalid_i = 4'b0000;
      chk("ar_pre_errs", 32'(errs_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("ar_state", 32'(state_o), 32'd0);
      chk("ar_cap_rst", 32'(cap_rst_o), 32'd1);
      chk("ar_cap_ce", 32'(cap_ce_o), 32'd0);
      chk("ar_run", 32'(run_o), 32'd0);
      chk("ar_ack", 32'(ack_o), 32'h0);
      chk("ar_errs", 32'(errs_o), 32'd0);
      chk("ar_lost", 32'(lost_o), 32'h0);
      en_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      chk("ar_release_idle", 32'(state_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
